pc_redirect_controller: RTL and testbench
=========================================

// Module: pc_redirect_controller
// PURPOSE
//  Sequences the program counter: arbitrates redirect requests (trap, EX branch/jump, ID jump).
//  Drives the PC's we/write_addr/stall, holds redirects that cannot be taken yet,
//  and issues pipeline flushes.
//  Also owns boot hold-off and halt/resume. Sits between hazard unit, fetch and program_counter.
// PARAMETERS
//  BOOT_CYCLES   4             cycles pc_stall held after reset release before first fetch advance
//  TRAP_VECTOR   32'h0000_0010 redirect address used when a non-trap target is misaligned
// PORTS
//  clk            in   1   core clock, all state on posedge
//  rst            in   1   asynchronous, active-low reset
//  trap_req       in   1   trap/exception redirect request (highest priority)
//  trap_target    in   32  trap handler address
//  ex_redirect    in   1   resolved branch/jump redirect from EX
//  ex_target      in   32  EX redirect address
//  id_redirect    in   1   early jump redirect from ID (lowest priority)
//  id_target      in   32  ID redirect address
//  hazard_stall   in   1   pipeline hazard hold request
//  imem_ready     in   1   fetch can accept a new PC this cycle
//  halt_req       in   1   request to halt fetch (e.g. ebreak)
//  resume         in   1   leave HALT
//  pc_we          out  1   load pc_write_addr into PC (never high while pc_stall high)
//  pc_write_addr  out  32  redirect address to PC
//  pc_stall       out  1   freeze PC
//  flush_if       out  1   squash IF stage instruction
//  flush_id       out  1   squash ID stage instruction
//  halted         out  1   controller in HALT
//  misalign       out  1   one-cycle pulse: selected non-trap target had target[1:0]!=0
// BEHAVIOUR
//  Reset (rst=0, async): state=BOOT, boot counter=0, pending cleared; pc_we=0, pc_stall=1,
//   flush_if=flush_id=0, halted=0, misalign=0, pc_write_addr=0. Reset mid-HOLD discards pending target.
//  adv = imem_ready & ~hazard_stall. Trap ignores hazard_stall: trap advances on imem_ready alone.
//  All outputs combinational from state + inputs; PC updates on the edge ending the pc_we cycle.
//  BOOT: pc_stall=1, counter increments each cycle; after BOOT_CYCLES cycles -> RUN. Redirects ignored.
//  RUN: select trap > ex > id; class T/E/I. Target of E/I with [1:0]!=0 -> TRAP_VECTOR,
//   misalign=1, class becomes T.
//   Redirect & adv: pc_we=1, pc_stall=0, pc_write_addr=target.
//    Flush rules: T/E -> flush_if=flush_id=1; I -> flush_if=1 only.
//   Redirect & !adv: latch target+class into pending, pc_stall=1, pc_we=0 -> HOLD
//    (misalign pulses once, in the latch cycle).
//   No redirect: pc_stall=~adv, pc_we=0 (PC increments sequentially).
//   halt_req with no redirect: -> HALT next edge. Redirect wins over simultaneous halt_req.
//  HOLD: pc_stall=1 until adv (trap class: imem_ready). New request of higher or equal class
//   replaces pending (T replaces any; E replaces E/I; I replaces I only). On adv: pc_we=1,
//   pc_stall=0 with pending target. Flush per pending class; -> RUN. halt_req ignored in HOLD.
//  HALT: halted=1, pc_stall=1. E/I redirects dropped. trap_req -> handled as in RUN
//   (immediate or via HOLD), halted deasserts. resume (no trap) -> RUN next edge.
//  Target arithmetic: 32-bit pass-through, no offset added here; PC wraps naturally at 2^32.
// CONFIGURATION
//  PC_REDIRECT_PERF_EN: defined -> extra port redirect_count out 32; increments once per pc_we
//   pulse, wraps at 2^32, cleared by reset. Undefined -> port and counter absent, behaviour else identical.
// TESTING
//  Reset release -> pc_stall=1 for exactly 4 cycles, then pc_we=0, pc_stall=0 with imem_ready=1.
//  RUN, adv, ex_redirect=1 ex_target=0x100 -> same cycle pc_we=1, addr 0x100, flush_if=flush_id=1.
//  Same cycle trap_req(0x200)+ex(0x100)+id(0x80) -> addr 0x200, ex/id dropped.
//  id_redirect 0x40 with imem_ready=0 for 3 cycles, ex 0x300 arrives cycle 2 -> pc_stall=1 x3, then pc_we, addr 0x300, flush both.
//  ex_target 0x102 -> addr 0x10, misalign=1 one cycle, flush both.
//  halt_req -> halted=1, pc_stall=1; ex_redirect ignored; resume -> RUN.
//   With PC_REDIRECT_PERF_EN: 3 redirects -> redirect_count=3.

Source files
------------

// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller: sequences the program counter. Arbitrates trap > EX > ID redirects,
//   parks a redirect that fetch cannot take yet, issues IF/ID flushes, and owns boot hold-off
//   and halt/resume.
// Latency: outputs are combinational from state + inputs (0 cycles); the PC loads on the edge
//   that ends a pc_we cycle.
// Backpressure: imem_ready low (or hazard_stall for non-trap classes) parks the winning redirect
//   in HOLD with pc_stall=1 until it can advance.
//
// Ports:
//   clk, rst                  core clock (posedge) and asynchronous active-low reset
//   trap_req/trap_target      trap redirect, highest priority, advances on imem_ready alone
//   ex_redirect/ex_target     resolved branch/jump redirect from EX
//   id_redirect/id_target     early jump redirect from ID, lowest priority
//   hazard_stall, imem_ready  advance qualifiers for the PC
//   halt_req, resume          enter / leave HALT
//   pc_we, pc_write_addr      load redirect address into the PC (addr reads 0 when pc_we=0)
//   pc_stall                  freeze the PC
//   flush_if, flush_id        squash the IF / ID stage instruction
//   halted                    controller sits in HALT
//   misalign                  one-cycle pulse: chosen EX/ID target was not word aligned
//
// Optional build macro: PC_REDIRECT_PERF_EN adds output redirect_count[31:0], which counts
//   pc_we pulses (wraps at 2^32, cleared by reset).

module pc_redirect_controller #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_req,
    input  logic [31:0] trap_target,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        id_redirect,
    input  logic [31:0] id_target,
    input  logic        hazard_stall,
    input  logic        imem_ready,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_we,
    output logic [31:0] pc_write_addr,
    output logic        pc_stall,
    output logic        flush_if,
    output logic        flush_id,
    output logic        halted,
`ifdef PC_REDIRECT_PERF_EN
    output logic [31:0] redirect_count,
`endif
    output logic        misalign
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    // Redirect classes, encoded so a numeric compare gives priority order.
    localparam logic [1:0] CLS_I = 2'd0;
    localparam logic [1:0] CLS_E = 2'd1;
    localparam logic [1:0] CLS_T = 2'd2;

    // BOOT_CYCLES must be at least 1; the counter runs 0 .. BOOT_CYCLES-1.
    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic [1:0]       pend_cls_q, pend_cls_d;
    // Pending entry came from a misaligned EX/ID target: stops a requester
    // that keeps re-asserting the same bad target from re-pulsing misalign.
    logic             pend_mis_q, pend_mis_d;

    // ------------------------------------------------------------------
    // Request selection: trap > EX > ID. A misaligned EX/ID target is
    // rewritten to TRAP_VECTOR and promoted to trap class, so from here on it
    // behaves exactly like a trap (flush both, advance on imem_ready alone).
    // ------------------------------------------------------------------
    logic        req_vld;
    logic [1:0]  req_cls;
    logic [31:0] req_tgt;
    logic        req_mis;

    always_comb begin
        req_vld = 1'b0;
        req_cls = CLS_I;
        req_tgt = '0;
        req_mis = 1'b0;
        if (trap_req) begin
            req_vld = 1'b1;
            req_cls = CLS_T;
            req_tgt = trap_target;
        end else if (ex_redirect) begin
            req_vld = 1'b1;
            if (ex_target[1:0] != 2'b00) begin
                req_cls = CLS_T;
                req_tgt = TRAP_VECTOR;
                req_mis = 1'b1;
            end else begin
                req_cls = CLS_E;
                req_tgt = ex_target;
            end
        end else if (id_redirect) begin
            req_vld = 1'b1;
            if (id_target[1:0] != 2'b00) begin
                req_cls = CLS_T;
                req_tgt = TRAP_VECTOR;
                req_mis = 1'b1;
            end else begin
                req_cls = CLS_I;
                req_tgt = id_target;
            end
        end
    end

    // Normal advance needs fetch ready and no hazard; traps ignore hazards.
    logic adv_norm;
    logic req_adv;
    assign adv_norm = imem_ready & ~hazard_stall;
    assign req_adv  = (req_cls == CLS_T) ? imem_ready : adv_norm;

    // ------------------------------------------------------------------
    // HOLD replacement: an incoming request of equal or higher class
    // overwrites the parked one. The replacement takes effect in the same
    // cycle, so if fetch frees up on that cycle the newest winner issues.
    // ------------------------------------------------------------------
    logic        hold_replace;
    logic [31:0] eff_tgt;
    logic [1:0]  eff_cls;
    logic        eff_mis;
    logic        eff_adv;

    assign hold_replace = req_vld & (req_cls >= pend_cls_q);
    assign eff_tgt      = hold_replace ? req_tgt : pend_tgt_q;
    assign eff_cls      = hold_replace ? req_cls : pend_cls_q;
    assign eff_mis      = hold_replace ? req_mis : pend_mis_q;
    assign eff_adv      = (eff_cls == CLS_T) ? imem_ready : adv_norm;

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    logic        issue;      // a redirect is written into the PC this cycle
    logic [31:0] issue_tgt;
    logic [1:0]  issue_cls;
    logic        stall_idle; // pc_stall when no redirect is issued

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pend_tgt_d = pend_tgt_q;
        pend_cls_d = pend_cls_q;
        pend_mis_d = pend_mis_q;
        issue      = 1'b0;
        issue_tgt  = '0;
        issue_cls  = CLS_I;
        stall_idle = 1'b1;
        halted     = 1'b0;
        misalign   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Redirects are ignored until the boot hold-off expires.
                if (boot_cnt_q == BOOT_LAST) begin
                    boot_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (req_vld) begin
                    // Redirect beats a simultaneous halt_req.
                    misalign = req_mis;
                    if (req_adv) begin
                        issue     = 1'b1;
                        issue_tgt = req_tgt;
                        issue_cls = req_cls;
                    end else begin
                        pend_tgt_d = req_tgt;
                        pend_cls_d = req_cls;
                        pend_mis_d = req_mis;
                        state_d    = ST_HOLD;
                    end
                end else begin
                    // Sequential fetch: the PC steps whenever it may advance.
                    stall_idle = ~adv_norm;
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end
                end
            end

            ST_HOLD: begin
                // halt_req has no effect while a redirect is parked.
                misalign = hold_replace & req_mis & ~pend_mis_q;
                if (eff_adv) begin
                    issue     = 1'b1;
                    issue_tgt = eff_tgt;
                    issue_cls = eff_cls;
                    state_d   = ST_RUN;
                end else begin
                    pend_tgt_d = eff_tgt;
                    pend_cls_d = eff_cls;
                    pend_mis_d = eff_mis;
                end
            end

            default: begin // ST_HALT
                // Only a trap breaks out of HALT; EX/ID redirects are dropped.
                if (trap_req) begin
                    if (imem_ready) begin
                        issue     = 1'b1;
                        issue_tgt = trap_target;
                        issue_cls = CLS_T;
                        state_d   = ST_RUN;
                    end else begin
                        pend_tgt_d = trap_target;
                        pend_cls_d = CLS_T;
                        pend_mis_d = 1'b0;
                        state_d    = ST_HOLD;
                    end
                end else begin
                    halted = 1'b1;
                    if (resume) begin
                        state_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC-side outputs. pc_write_addr is zeroed when not writing so a stale
    // target never appears on the bus; pc_we and pc_stall are exclusive.
    // ID-class redirects leave the ID stage alone: the instruction in ID is
    // the jump itself.
    // ------------------------------------------------------------------
    always_comb begin
        pc_we         = issue;
        pc_stall      = issue ? 1'b0 : stall_idle;
        pc_write_addr = issue ? issue_tgt : 32'h0;
        flush_if      = issue;
        flush_id      = issue & (issue_cls != CLS_I);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            pend_tgt_q <= '0;
            pend_cls_q <= CLS_I;
            pend_mis_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pend_tgt_q <= pend_tgt_d;
            pend_cls_q <= pend_cls_d;
            pend_mis_q <= pend_mis_d;
        end
    end

`ifdef PC_REDIRECT_PERF_EN
    // ------------------------------------------------------------------
    // Redirect counter: one count per pc_we pulse, free-running wrap.
    // ------------------------------------------------------------------
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        redirect_count_d = redirect_count_q;
        if (pc_we) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_count_q <= '0;
        end else begin
            redirect_count_q <= redirect_count_d;
        end
    end

    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb_pc_redirect_controller: directed scenarios plus a randomized run against a
//   cycle-level reference model of the PC redirect rules.
// Inputs are driven 1 time unit after posedge and outputs sampled at negedge.
module tb_pc_redirect_controller;

    localparam logic [31:0] TV = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_req, ex_redirect, id_redirect;
    logic [31:0] trap_target, ex_target, id_target;
    logic        hazard_stall, imem_ready, halt_req, resume;
    logic        pc_we, pc_stall, flush_if, flush_id, halted, misalign;
    logic [31:0] pc_write_addr;
`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] redirect_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_we, pc_stall, flush_if, flush_id, halted, misalign}
    logic [5:0] ctl;
    assign ctl = {pc_we, pc_stall, flush_if, flush_id, halted, misalign};

    always #5 clk = ~clk;

    pc_redirect_controller dut (
        .clk           (clk),
        .rst           (rst),
        .trap_req      (trap_req),
        .trap_target   (trap_target),
        .ex_redirect   (ex_redirect),
        .ex_target     (ex_target),
        .id_redirect   (id_redirect),
        .id_target     (id_target),
        .hazard_stall  (hazard_stall),
        .imem_ready    (imem_ready),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc_we         (pc_we),
        .pc_write_addr (pc_write_addr),
        .pc_stall      (pc_stall),
        .flush_if      (flush_if),
        .flush_id      (flush_id),
        .halted        (halted),
`ifdef PC_REDIRECT_PERF_EN
        .redirect_count(redirect_count),
`endif
        .misalign      (misalign)
    );

    task automatic idle();
        trap_req = 1'b0; trap_target = '0;
        ex_redirect = 1'b0; ex_target = '0;
        id_redirect = 1'b0; id_target = '0;
        hazard_stall = 1'b0; imem_ready = 1'b1;
        halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset state, then exactly BOOT_CYCLES=4 stalled cycles before RUN.
    task automatic test_reset();
        idle();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b010000 || pc_write_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state ctl=%b addr=%h expected ctl=010000 addr=00000000", ctl, pc_write_addr);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (ctl !== 6'b010000) begin
                n_fail++;
                $display("FAIL boot_stall cycle %0d ctl=%b expected 010000", i, ctl);
            end
        end
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++;
            $display("FAIL boot_done ctl=%b expected 000000", ctl);
        end
    endtask

    task automatic test_ex_redirect();
        logic [5:0] ec; logic [31:0] ea;
        for (int i = 0; i < 4; i++) begin
            step(); idle();
            ec = 6'b000000; ea = 32'h0;
            case (i)
                0: begin ex_redirect = 1; ex_target = 32'h100; ec = 6'b101100; ea = 32'h100; end
                2: begin ex_redirect = 1; ex_target = 32'hFFFF_FFFC; ec = 6'b101100; ea = 32'hFFFF_FFFC; end
                default: ;
            endcase
            @(negedge clk);
            n_checks++;
            if (ctl !== ec || pc_write_addr !== ea) begin
                n_fail++;
                $display("FAIL ex_redirect step %0d ctl=%b addr=%h expected ctl=%b addr=%h", i, ctl, pc_write_addr, ec, ea);
            end
        end
    endtask

    task automatic test_priority();
        logic [5:0] ec; logic [31:0] ea;
        for (int i = 0; i < 4; i++) begin
            step(); idle();
            ec = 6'b000000; ea = 32'h0;
            case (i)
                0: begin
                    trap_req = 1; trap_target = 32'h200;
                    ex_redirect = 1; ex_target = 32'h100;
                    id_redirect = 1; id_target = 32'h80;
                    ec = 6'b101100; ea = 32'h200;
                end
                2: begin
                    ex_redirect = 1; ex_target = 32'h100;
                    id_redirect = 1; id_target = 32'h80;
                    ec = 6'b101100; ea = 32'h100;
                end
                default: ;
            endcase
            @(negedge clk);
            n_checks++;
            if (ctl !== ec || pc_write_addr !== ea) begin
                n_fail++;
                $display("FAIL priority step %0d ctl=%b addr=%h expected ctl=%b addr=%h", i, ctl, pc_write_addr, ec, ea);
            end
        end
    endtask

    // Parked redirects, replacement by class, and ID-only flush.
    task automatic test_hold();
        logic [5:0] ec; logic [31:0] ea;
        for (int i = 0; i < 12; i++) begin
            step(); idle();
            ec = 6'b010000; ea = 32'h0;
            case (i)
                0: begin id_redirect = 1; id_target = 32'h40; imem_ready = 0; end
                1: begin ex_redirect = 1; ex_target = 32'h300; imem_ready = 0; end
                2: imem_ready = 0;
                3: begin ec = 6'b101100; ea = 32'h300; end
                4: ec = 6'b000000;
                5: begin id_redirect = 1; id_target = 32'h44; imem_ready = 0; end
                6: hazard_stall = 1;
                7: begin ec = 6'b101000; ea = 32'h44; end
                8: begin id_redirect = 1; id_target = 32'h88; imem_ready = 0; end
                9: begin trap_req = 1; trap_target = 32'h400; imem_ready = 0; end
                10: begin ex_redirect = 1; ex_target = 32'h500; ec = 6'b101100; ea = 32'h400; end
                default: ec = 6'b000000;
            endcase
            @(negedge clk);
            n_checks++;
            if (ctl !== ec || pc_write_addr !== ea) begin
                n_fail++;
                $display("FAIL hold step %0d ctl=%b addr=%h expected ctl=%b addr=%h", i, ctl, pc_write_addr, ec, ea);
            end
        end
    endtask

    task automatic test_misalign();
        logic [5:0] ec; logic [31:0] ea;
        for (int i = 0; i < 9; i++) begin
            step(); idle();
            ec = 6'b000000; ea = 32'h0;
            case (i)
                0: begin ex_redirect = 1; ex_target = 32'h102; ec = 6'b101101; ea = TV; end
                2: begin id_redirect = 1; id_target = 32'h81; hazard_stall = 1; ec = 6'b101101; ea = TV; end
                3: begin id_redirect = 1; id_target = 32'h80; ec = 6'b101000; ea = 32'h80; end
                4: begin id_redirect = 1; id_target = 32'h83; imem_ready = 0; ec = 6'b010001; end
                5: begin imem_ready = 0; ec = 6'b010000; end
                6: begin ec = 6'b101100; ea = TV; end
                7: begin trap_req = 1; trap_target = 32'h202; ec = 6'b101100; ea = 32'h202; end
                default: ;
            endcase
            @(negedge clk);
            n_checks++;
            if (ctl !== ec || pc_write_addr !== ea) begin
                n_fail++;
                $display("FAIL misalign step %0d ctl=%b addr=%h expected ctl=%b addr=%h", i, ctl, pc_write_addr, ec, ea);
            end
        end
    endtask

    task automatic test_trap_hazard();
        logic [5:0] ec; logic [31:0] ea;
        for (int i = 0; i < 6; i++) begin
            step(); idle();
            ec = 6'b010000; ea = 32'h0;
            case (i)
                0: begin trap_req = 1; trap_target = 32'h300; hazard_stall = 1; ec = 6'b101100; ea = 32'h300; end
                1: begin ex_redirect = 1; ex_target = 32'h200; hazard_stall = 1; end
                2: hazard_stall = 1;
                3: begin ec = 6'b101100; ea = 32'h200; end
                4: hazard_stall = 1;
                default: ec = 6'b000000;
            endcase
            @(negedge clk);
            n_checks++;
            if (ctl !== ec || pc_write_addr !== ea) begin
                n_fail++;
                $display("FAIL trap_hazard step %0d ctl=%b addr=%h expected ctl=%b addr=%h", i, ctl, pc_write_addr, ec, ea);
            end
        end
    endtask

    task automatic test_halt();
        logic [5:0] ec; logic [31:0] ea;
        for (int i = 0; i < 14; i++) begin
            step(); idle();
            ec = 6'b000000; ea = 32'h0;
            case (i)
                0: halt_req = 1;
                1: ec = 6'b010010;
                2: begin ex_redirect = 1; ex_target = 32'h100; ec = 6'b010010; end
                3: begin resume = 1; ec = 6'b010010; end
                5: halt_req = 1;
                6: begin trap_req = 1; trap_target = 32'h200; ec = 6'b101100; ea = 32'h200; end
                8: begin ex_redirect = 1; ex_target = 32'h100; halt_req = 1; ec = 6'b101100; ea = 32'h100; end
                10: halt_req = 1;
                11: begin trap_req = 1; trap_target = 32'h240; imem_ready = 0; ec = 6'b010000; end
                12: begin ec = 6'b101100; ea = 32'h240; end
                default: ;
            endcase
            @(negedge clk);
            n_checks++;
            if (ctl !== ec || pc_write_addr !== ea) begin
                n_fail++;
                $display("FAIL halt step %0d ctl=%b addr=%h expected ctl=%b addr=%h", i, ctl, pc_write_addr, ec, ea);
            end
        end
    endtask

    // Reset while a redirect is parked must discard it.
    task automatic test_reset_mid_hold();
        step(); idle();
        ex_redirect = 1; ex_target = 32'h180; imem_ready = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        idle();
        #1;
        n_checks++;
        if (ctl !== 6'b010000 || pc_write_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_hold ctl=%b addr=%h expected ctl=010000 addr=00000000", ctl, pc_write_addr);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b000000 || pc_write_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL pending_discarded ctl=%b addr=%h expected ctl=000000 addr=00000000", ctl, pc_write_addr);
        end
    endtask

`ifdef PC_REDIRECT_PERF_EN
    task automatic test_perf();
        step(); idle(); rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (redirect_count !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset count=%0d expected 0", redirect_count);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            idle();
            ex_redirect = 1; ex_target = 32'h1000 + 32'(i * 4);
            step();
        end
        idle();
        @(negedge clk);
        n_checks++;
        if (redirect_count !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_count count=%0d expected 3", redirect_count);
        end
    endtask
`endif

    // Randomized run against a reference model of the redirect rules.
    // Class rank: ID=1, EX=2, trap (incl. promoted misaligned)=3.
    task automatic test_random();
        int          boot_left, p_rank, r_rank, g_rank, n_p_rank;
        bit          in_hold, in_halt, p_mis, n_hold, n_halt, n_p_mis;
        bit          r_vld, r_mis, go, e_stall, e_halt, e_mis;
        logic [31:0] p_tgt, n_p_tgt, r_tgt, g_tgt, e_addr;
        logic [5:0]  e_ctl;

        step(); idle(); rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        boot_left = 4; in_hold = 0; in_halt = 0;
        p_tgt = '0; p_rank = 0; p_mis = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) step();
            trap_req     = ($urandom_range(0, 15) == 0);
            ex_redirect  = ($urandom_range(0, 7) == 0);
            id_redirect  = ($urandom_range(0, 7) == 0);
            trap_target  = $urandom;
            ex_target    = $urandom;
            id_target    = $urandom;
            if ($urandom_range(0, 3) != 0) ex_target[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) id_target[1:0] = 2'b00;
            imem_ready   = ($urandom_range(0, 3) != 0);
            hazard_stall = ($urandom_range(0, 3) == 0);
            halt_req     = ($urandom_range(0, 15) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            @(negedge clk);

            r_vld = 0; r_rank = 0; r_tgt = '0; r_mis = 0;
            if (trap_req) begin
                r_vld = 1; r_rank = 3; r_tgt = trap_target;
            end else if (ex_redirect || id_redirect) begin
                r_vld = 1;
                r_tgt = ex_redirect ? ex_target : id_target;
                r_rank = ex_redirect ? 2 : 1;
                if (r_tgt % 4 != 0) begin
                    r_rank = 3; r_tgt = TV; r_mis = 1;
                end
            end

            go = 0; g_tgt = '0; g_rank = 0;
            e_stall = 1; e_halt = 0; e_mis = 0;
            n_hold = in_hold; n_halt = in_halt;
            n_p_tgt = p_tgt; n_p_rank = p_rank; n_p_mis = p_mis;

            if (boot_left > 0) begin
                boot_left--;
            end else if (in_hold) begin
                if (r_vld && r_rank >= p_rank) begin
                    e_mis = r_mis && !p_mis;
                    n_p_tgt = r_tgt; n_p_rank = r_rank; n_p_mis = r_mis;
                end
                if (n_p_rank == 3 ? imem_ready : (imem_ready && !hazard_stall)) begin
                    go = 1; g_tgt = n_p_tgt; g_rank = n_p_rank; n_hold = 0;
                end
            end else if (in_halt) begin
                if (trap_req) begin
                    n_halt = 0;
                    if (imem_ready) begin
                        go = 1; g_tgt = trap_target; g_rank = 3;
                    end else begin
                        n_hold = 1; n_p_tgt = trap_target; n_p_rank = 3; n_p_mis = 0;
                    end
                end else begin
                    e_halt = 1;
                    if (resume) n_halt = 0;
                end
            end else begin
                if (r_vld) begin
                    e_mis = r_mis;
                    if (r_rank == 3 ? imem_ready : (imem_ready && !hazard_stall)) begin
                        go = 1; g_tgt = r_tgt; g_rank = r_rank;
                    end else begin
                        n_hold = 1; n_p_tgt = r_tgt; n_p_rank = r_rank; n_p_mis = r_mis;
                    end
                end else begin
                    e_stall = !(imem_ready && !hazard_stall);
                    if (halt_req) n_halt = 1;
                end
            end

            if (go) e_stall = 0;
            e_ctl  = {go, e_stall, go, go && (g_rank != 1), e_halt, e_mis};
            e_addr = go ? g_tgt : 32'h0;

            n_checks++;
            if (ctl !== e_ctl) begin
                n_fail++;
                $display("FAIL random_ctl cycle %0d ctl=%b expected %b", cyc, ctl, e_ctl);
            end
            n_checks++;
            if (pc_write_addr !== e_addr) begin
                n_fail++;
                $display("FAIL random_addr cycle %0d addr=%h expected %h", cyc, pc_write_addr, e_addr);
            end

            in_hold = n_hold; in_halt = n_halt;
            p_tgt = n_p_tgt; p_rank = n_p_rank; p_mis = n_p_mis;
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_ex_redirect();
        test_priority();
        test_hold();
        test_misalign();
        test_trap_hazard();
        test_halt();
        test_reset_mid_hold();
`ifdef PC_REDIRECT_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
